// File: rtl/req_debounce_latch_pkg.sv
// req_debounce_latch_pkg: shared ack codes, default debounce length and ack decode helper
package req_debounce_latch_pkg;
  localparam int DEBOUNCE_DEFAULT = 4;
  typedef enum logic [1:0] {
    ACK_NONE = 2'd0,
    ACK_CH0  = 2'd1,
    ACK_CH1  = 2'd2,
    ACK_CH2  = 2'd3
  } ack_code_e;
  function automatic logic [2:0] ack_onehot(input logic ack, input logic [1:0] code);
    logic [3:0] t;
    t = 4'b0001 << code;
    return ack ? t[3:1] : 3'b000;
  endfunction
endpackage

// File: rtl/sync_debounce.sv
// sync_debounce: 2-flop sync + debounce counter; ports clk, rst_n, raw in, clean level out, rise (clean goes high on the coming edge)
module sync_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic clean,
  output logic rise
);
  logic [1:0] sync;
  logic [CNT_W-1:0] cnt;
  logic diff, done;
  assign diff = sync[1] ^ clean;
  assign done = cnt == CNT_W'(DEBOUNCE_CYCLES - 1);
  assign rise = diff && done && sync[1];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      cnt   <= '0;
      clean <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      cnt   <= (diff && !done) ? cnt + 1'b1 : '0;
      clean <= (diff && done) ? sync[1] : clean;
    end
  end
endmodule

// File: rtl/req_debounce_latch.sv
// req_debounce_latch: debounced sticky request latch; ports clk, rst_n, raw_in[2:0], ack, ack_code -> in2..in0, any_req, overrun[2:0]
module req_debounce_latch
  import req_debounce_latch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] raw_in,
  input  logic [1:0] ack_code,
  input  logic       ack,
  output logic       in2,
  output logic       in1,
  output logic       in0,
  output logic       any_req,
  output logic [2:0] overrun
);
  logic [2:0] clean, rise, clr, lat, lat_nxt;
  for (genvar i = 0; i < 3; i++) begin : g_ch
    sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (raw_in[i]),
      .clean(clean[i]),
      .rise (rise[i])
    );
  end
  assign clr = ack_onehot(ack, ack_code);
  assign lat_nxt = rise | (lat & ~clr);
  assign {in2, in1, in0} = lat;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat     <= '0;
      any_req <= 1'b0;
      overrun <= '0;
    end else begin
      lat     <= lat_nxt;
      any_req <= |lat_nxt;
      overrun <= rise & lat & ~clr;
    end
  end
  assert property (@(posedge clk) disable iff (!rst_n) (rise & clean) == 3'b000);
endmodule

// File: tb/tb_req_debounce_latch.sv
// tb_req_debounce_latch: directed + random checks of req_debounce_latch against a sliding-window reference model
module tb_req_debounce_latch;
  import req_debounce_latch_pkg::*;
  localparam int D = DEBOUNCE_DEFAULT;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [2:0] raw_in = '0;
  logic [1:0] ack_code = '0;
  logic ack = 1'b0;
  logic in2, in1, in0, any_req;
  logic [2:0] overrun;
  int checks = 0;
  int errors = 0;
  logic [2:0] hist[$];
  logic [2:0] m_clean, m_in, m_ovr;
  logic m_any;

  req_debounce_latch dut (
    .clk(clk), .rst_n(rst_n), .raw_in(raw_in), .ack_code(ack_code), .ack(ack),
    .in2(in2), .in1(in1), .in0(in0), .any_req(any_req), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] enc(input logic [2:0] v);
    return v[2] ? 2'd3 : v[1] ? 2'd2 : v[0] ? 2'd1 : 2'd0;
  endfunction

  task automatic model_reset();
    hist = {};
    for (int k = 0; k < D + 2; k++) hist.push_back(3'b000);
    m_clean = '0;
    m_in = '0;
    m_ovr = '0;
    m_any = 1'b0;
  endtask

  // clean flips once the last D synchronized samples (raw taken two edges earlier) all disagree with it
  task automatic model_edge(input logic [2:0] r, input logic a, input logic [1:0] c);
    logic [2:0] nc, rise, clr, s;
    logic all_diff;
    hist.push_back(r);
    void'(hist.pop_front());
    nc = m_clean;
    for (int ch = 0; ch < 3; ch++) begin
      all_diff = 1'b1;
      for (int k = 0; k < D; k++) begin
        s = hist[k];
        if (s[ch] == m_clean[ch]) all_diff = 1'b0;
      end
      if (all_diff) nc[ch] = ~m_clean[ch];
      clr[ch] = a && (int'(c) == ch + 1);
    end
    rise = nc & ~m_clean;
    m_ovr = rise & m_in & ~clr;
    m_in = rise | (m_in & ~clr);
    m_any = |m_in;
    m_clean = nc;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_in"}, {29'd0, in2, in1, in0}, {29'd0, m_in});
    check({tag, "_ovr"}, {29'd0, overrun}, {29'd0, m_ovr});
    check({tag, "_any"}, {31'd0, any_req}, {31'd0, m_any});
  endtask

  task automatic step(input logic [2:0] r, input logic a, input logic [1:0] c, input string tag);
    raw_in = r;
    ack = a;
    ack_code = c;
    @(posedge clk);
    if (rst_n) model_edge(r, a, c);
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst", {25'd0, in2, in1, in0, any_req, overrun}, 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int ov_cnt;
    logic [2:0] r;
    model_reset();
    do_reset();
    for (int k = 0; k < 4; k++) step(3'b000, 1'b0, ACK_NONE, "idle");
    for (int k = 0; k <= D + 1; k++) begin
      step(3'b010, 1'b0, ACK_NONE, "lat1");
      check("lat1_edge", {31'd0, in1}, {31'd0, k == D + 1});
      check("lat1_any", {31'd0, any_req}, {31'd0, k == D + 1});
    end
    for (int k = 0; k < D - 1; k++) step(3'b011, 1'b0, ACK_NONE, "glitch_hi");
    for (int k = 0; k < D + 2; k++) begin
      step(3'b010, 1'b0, ACK_NONE, "glitch_lo");
      check("glitch_in0", {31'd0, in0}, 32'd0);
    end
    for (int k = 0; k <= D + 1; k++) step(3'b110, 1'b0, ACK_NONE, "lat2");
    check("lat2_set", {31'd0, in2}, 32'd1);
    step(3'b110, 1'b1, ACK_NONE, "ack_none");
    check("ack_none_in2", {31'd0, in2}, 32'd1);
    step(3'b110, 1'b1, ACK_CH2, "ack_ch2");
    check("ack_ch2_in2", {31'd0, in2}, 32'd0);
    for (int k = 0; k <= D + 1; k++) step(3'b100, 1'b0, ACK_NONE, "ch1_low");
    ov_cnt = 0;
    for (int k = 0; k <= D + 1; k++) begin
      step(3'b110, 1'b0, ACK_NONE, "ovr");
      ov_cnt += int'(overrun[1]);
      check("ovr_in1", {31'd0, in1}, 32'd1);
    end
    check("ovr_pulses", ov_cnt, 1);
    for (int k = 0; k <= D + 1; k++) step(3'b100, 1'b0, ACK_NONE, "ch1_low2");
    for (int k = 0; k <= D + 1; k++) step(3'b110, k == D + 1, ACK_CH1, "set_wins");
    check("set_wins_in1", {31'd0, in1}, 32'd1);
    check("set_wins_ovr", {31'd0, overrun[1]}, 32'd0);
    for (int k = 0; k <= D + 1; k++) step(3'b000, 1'b0, ACK_NONE, "drop");
    for (int c = 1; c < 4; c++) step(3'b000, 1'b1, 2'(c), "clear");
    check("cleared", {28'd0, in2, in1, in0, any_req}, 32'd0);
    for (int k = 0; k <= D + 1; k++) step(3'b011, 1'b0, ACK_NONE, "enc");
    check("enc_10", {30'd0, enc({in2, in1, in0})}, 32'd2);
    step(3'b011, 1'b1, ACK_CH1, "enc_ack1");
    check("enc_01", {30'd0, enc({in2, in1, in0})}, 32'd1);
    step(3'b011, 1'b1, ACK_CH0, "enc_ack0");
    check("enc_any0", {31'd0, any_req}, 32'd0);
    for (int k = 0; k <= D + 1; k++) step(3'b111, 1'b0, ACK_NONE, "pre_rst_hi");
    for (int k = 0; k <= D + 1; k++) step(3'b000, 1'b0, ACK_NONE, "pre_rst_lo");
    for (int k = 0; k < 4; k++) step(3'b111, 1'b0, ACK_NONE, "mid_count");
    do_reset();
    for (int k = 0; k <= D + 1; k++) begin
      step(3'b111, 1'b0, ACK_NONE, "post_rst");
      check("post_rst_lat", {29'd0, in2, in1, in0}, (k == D + 1) ? 32'd7 : 32'd0);
    end
    r = 3'b000;
    for (int k = 0; k < 600; k++) begin
      for (int ch = 0; ch < 3; ch++) if ($urandom_range(0, 5) == 0) r[ch] = ~r[ch];
      if ($urandom_range(0, 199) == 0) do_reset();
      step(r, $urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)), "rand");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
